// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE Z store path: packer config, packer FSM states
// and a saturating counter helper.
package redmule_pkg;

    localparam int unsigned ZP_ARRAY_W   = 12;
    localparam int unsigned ZP_TOT_DEPTH = 16;
    localparam int unsigned ZP_ITER_W    = 16;
    localparam int unsigned ZP_ROWS_W    = $clog2(ZP_ARRAY_W) + 1;
    localparam int unsigned ZP_COLS_W    = $clog2(ZP_TOT_DEPTH) + 1;

    typedef struct packed {
        logic [ZP_ITER_W-1:0] x_row_iters;
        logic [ZP_ITER_W-1:0] w_col_iters;
        logic [ZP_ROWS_W-1:0] rows_lftovr;
        logic [ZP_COLS_W-1:0] cols_lftovr;
    } z_packer_cfg_t;

    typedef enum logic [1:0] {
        ZP_IDLE,
        ZP_RUN,
        ZP_DRAIN,
        ZP_DONE
    } z_packer_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/redmule_z_strb_gen.sv
// Element-count to byte-strobe mask. Bytes beyond the row payload (the upper
// MemDw part of the beat) are never enabled.
module redmule_z_strb_gen #(
    parameter int unsigned DATA_W = 288,
    parameter int unsigned DATAW  = 256,
    parameter int unsigned BITW   = 16,
    parameter int unsigned STRB   = DATA_W / 8,
    localparam int unsigned N_W   = $clog2(DATAW / BITW) + 1
) (
    input  logic [N_W-1:0]  n,
    output logic [STRB-1:0] strb
);

    // Enable the first n*BITW/8 bytes of the row payload.
    always_comb begin
        strb = '0;
        for (int unsigned k = 0; k < STRB; k++) begin
            if (k < DATAW / 8 && k < 32'(n) * BITW / 8) begin
                strb[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/redmule_z_store_packer.sv
// Z row to TCDM store beat packer with row/column/block tracking.
// Optional stall counter: define REDMULE_Z_STORE_PACKER_STALL_CNT_EN.
module redmule_z_store_packer
    import redmule_pkg::*;
#(
    parameter int unsigned DATA_W  = 288,
    parameter int unsigned DATAW   = 256,
    parameter int unsigned BITW    = 16,
    parameter int unsigned ARRAY_W = 12,
    parameter int unsigned STRB    = DATA_W / 8,
    localparam int unsigned TOT_DEPTH = DATAW / BITW,
    localparam int unsigned MEM_DW    = DATA_W - DATAW,
    localparam int unsigned ROWS_W    = $clog2(ARRAY_W) + 1,
    localparam int unsigned COLS_W    = $clog2(TOT_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [15:0]       x_row_iters_i,
    input  logic [15:0]       w_col_iters_i,
    input  logic [ROWS_W-1:0] rows_lftovr_i,
    input  logic [COLS_W-1:0] cols_lftovr_i,
    input  logic [DATAW-1:0]  in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [STRB-1:0]   out_strb_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       stored_cnt_o,
    output logic              done_o,
    output logic [31:0]       stall_cnt_o
);

    z_packer_state_e   state_q;
    z_packer_cfg_t     cfg_q;
    logic [ROWS_W-1:0] r_q;
    logic [15:0]       c_q;
    logic [15:0]       b_q;

    logic [ROWS_W-1:0] rows_in_tile;
    logic [COLS_W-1:0] n_elems;
    logic [STRB-1:0]   strb_mask;
    logic              last_r, last_c, last_b, last_beat;
    logic              in_fire, out_fire;

    // Position decode: tile height of the current block and width of the current tile.
    always_comb begin
        last_b       = (b_q == cfg_q.x_row_iters - 16'd1);
        last_c       = (c_q == cfg_q.w_col_iters - 16'd1);
        rows_in_tile = (last_b && cfg_q.rows_lftovr != '0) ? cfg_q.rows_lftovr
                                                           : ROWS_W'(ARRAY_W);
        n_elems      = (last_c && cfg_q.cols_lftovr != '0) ? cfg_q.cols_lftovr
                                                           : COLS_W'(TOT_DEPTH);
        last_r       = (r_q == rows_in_tile - ROWS_W'(1));
        last_beat    = last_r && last_c && last_b;
    end

    assign in_ready_o = (state_q == ZP_RUN) && (!out_valid_o || out_ready_i);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    redmule_z_strb_gen #(
        .DATA_W (DATA_W),
        .DATAW  (DATAW),
        .BITW   (BITW),
        .STRB   (STRB)
    ) u_strb_gen (
        .n    (n_elems),
        .strb (strb_mask)
    );

    // FSM, position counters, output register and store counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= ZP_IDLE;
            cfg_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            b_q          <= '0;
            out_data_o   <= '0;
            out_strb_o   <= '0;
            out_valid_o  <= 1'b0;
            stored_cnt_o <= '0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (out_fire) begin
                stored_cnt_o <= sat_inc32(stored_cnt_o);
            end
            if (in_fire) begin
                // Masked lanes keep their data; only the strobe hides them.
                out_data_o  <= {{MEM_DW{1'b0}}, in_data_i};
                out_strb_o  <= strb_mask;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            unique case (state_q)
                ZP_IDLE: begin
                    if (start_i) begin
                        cfg_q        <= '{x_row_iters: x_row_iters_i,
                                          w_col_iters: w_col_iters_i,
                                          rows_lftovr: rows_lftovr_i,
                                          cols_lftovr: cols_lftovr_i};
                        r_q          <= '0;
                        c_q          <= '0;
                        b_q          <= '0;
                        stored_cnt_o <= '0;
                        state_q      <= (x_row_iters_i == 16'd0) ? ZP_DONE : ZP_RUN;
                    end
                end
                ZP_RUN: begin
                    if (in_fire) begin
                        if (last_r) begin
                            r_q <= '0;
                            if (last_c) begin
                                c_q <= '0;
                                b_q <= b_q + 16'd1;
                            end else begin
                                c_q <= c_q + 16'd1;
                            end
                        end else begin
                            r_q <= r_q + ROWS_W'(1);
                        end
                        if (last_beat) begin
                            state_q <= ZP_DRAIN;
                        end
                    end
                end
                ZP_DRAIN: begin
                    if (!out_valid_o || out_ready_i) begin
                        state_q <= ZP_DONE;
                    end
                end
                ZP_DONE: begin
                    state_q <= ZP_IDLE;
                    done_o  <= 1'b1;
                end
            endcase
        end
    end

`ifdef REDMULE_Z_STORE_PACKER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where a held beat waits on the sink.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stall_cnt_q <= '0;
        end else if (state_q == ZP_IDLE && start_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid_o && !out_ready_i) begin
            stall_cnt_q <= sat_inc32(stall_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_redmule_z_store_packer.sv
// Directed bench for redmule_z_store_packer: full tiles, leftovers, random
// back-pressure, empty job, mid-job clear and ignored restart.
module tb_redmule_z_store_packer;

    localparam logic [35:0] FULL = 36'h0_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst, clear, start;
    logic [15:0]  x_row_iters, w_col_iters;
    logic [4:0]   rows_lftovr, cols_lftovr;
    logic [255:0] in_data;
    logic         in_valid, in_ready;
    logic [287:0] out_data;
    logic [35:0]  out_strb;
    logic         out_valid, out_ready;
    logic [31:0]  stored_cnt, stall_cnt;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    redmule_z_store_packer u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .start_i       (start),
        .x_row_iters_i (x_row_iters),
        .w_col_iters_i (w_col_iters),
        .rows_lftovr_i (rows_lftovr),
        .cols_lftovr_i (cols_lftovr),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .out_data_o    (out_data),
        .out_strb_o    (out_strb),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .stored_cnt_o  (stored_cnt),
        .done_o        (done),
        .stall_cnt_o   (stall_cnt)
    );

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] mk_row(input int i);
        return {8{32'hA500_0000 + 32'(i)}};
    endfunction

    // One job: start in cycle 0, config inputs scrambled afterwards to prove latching.
    // rdy_pct: chance out_ready is high. restart_at: cycle of a second start pulse.
    // abort_at: number of accepted beats after which clear is pulsed (-1 = never).
    task automatic run_job(input int x, input int w, input int rl, input int cl,
                           input logic [35:0] lstrb, input int rdy_pct,
                           input int restart_at, input int abort_at, input int exp_beats);
        logic [255:0] exp_q[$];
        logic [35:0]  strb_q[$];
        int cyc, sent, recv, stalls, done_cnt, last_out_cyc, abort_cyc;
        int mr, mc, mb, rows;
        bit prev_stall, saw_in_ready, abort_pend, aborted, finished;
        logic [287:0] prev_data;
        logic [35:0]  prev_strb;
        sent = 0; recv = 0; stalls = 0; done_cnt = 0; last_out_cyc = 0; abort_cyc = 0;
        mr = 0; mc = 0; mb = 0;
        prev_stall = 0; saw_in_ready = 0; abort_pend = 0; aborted = 0; finished = 0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (cyc == restart_at);
            if (cyc == 0) begin
                x_row_iters = 16'(x); w_col_iters = 16'(w);
                rows_lftovr = 5'(rl); cols_lftovr = 5'(cl);
            end else begin
                x_row_iters = 16'd5; w_col_iters = 16'd2;
                rows_lftovr = 5'd3;  cols_lftovr = 5'd1;
            end
            clear     = abort_pend;
            out_ready = abort_pend ? 1'b0 : ($urandom_range(99) < 32'(rdy_pct));
            in_valid  = !abort_pend && !aborted && (sent < exp_beats || exp_beats == 0);
            in_data   = mk_row(sent);
            #1;
            if (abort_pend) begin
                check("abort_valid_before", 288'(out_valid), 288'd1);
                abort_pend = 0; aborted = 1; abort_cyc = cyc; prev_stall = 0;
                continue;
            end
            if (aborted && cyc == abort_cyc + 1) begin
                check("abort_valid_after", 288'(out_valid), 288'd0);
                check("abort_in_ready", 288'(in_ready), 288'd0);
                check("abort_stored", 288'(stored_cnt), 288'd0);
            end
            if (prev_stall) begin
                check("hold_valid", 288'(out_valid), 288'd1);
                check("hold_data", out_data, prev_data);
                check("hold_strb", 288'(out_strb), 288'(prev_strb));
            end
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 288'd1, 288'd0);
                end else begin
                    check("out_data", out_data, {32'h0, exp_q.pop_front()});
                    check("out_strb", 288'(out_strb), 288'(strb_q.pop_front()));
                end
                recv++;
                last_out_cyc = cyc;
            end
            if (in_ready) saw_in_ready = 1;
            if (in_valid && in_ready && sent < exp_beats) begin
                rows = (mb == x - 1 && rl != 0) ? rl : 12;
                exp_q.push_back(in_data);
                strb_q.push_back((mc == w - 1 && cl != 0) ? lstrb : FULL);
                if (mr == rows - 1) begin
                    mr = 0;
                    if (mc == w - 1) begin mc = 0; mb++; end
                    else mc++;
                end else begin
                    mr++;
                end
                sent++;
                if (sent == abort_at) abort_pend = 1;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("done_latency", 288'(cyc - last_out_cyc), 288'd2);
                    check("stored_at_done", 288'(stored_cnt), 288'(exp_beats));
`ifdef REDMULE_Z_STORE_PACKER_STALL_CNT_EN
                    check("stall_cnt", 288'(stall_cnt), 288'(stalls));
`else
                    check("stall_cnt", 288'(stall_cnt), 288'd0);
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_strb  = out_strb;
            if (!aborted && done_cnt > 0 && cyc >= last_out_cyc + 6) begin finished = 1; break; end
            if (aborted && cyc >= abort_cyc + 12) begin finished = 1; break; end
        end
        start = 0; clear = 0; in_valid = 0;
        check("job_finished", 288'(finished), 288'd1);
        if (aborted) begin
            check("abort_no_done", 288'(done_cnt), 288'd0);
        end else begin
            check("done_once", 288'(done_cnt), 288'd1);
            check("beats_out", 288'(recv), 288'(exp_beats));
            check("queue_empty", 288'(exp_q.size()), 288'd0);
            if (exp_beats == 0) check("empty_in_ready", 288'(saw_in_ready), 288'd0);
        end
    endtask

    initial begin
        rst = 1; clear = 0; start = 0; in_valid = 0; out_ready = 0; in_data = '0;
        x_row_iters = '0; w_col_iters = '0; rows_lftovr = '0; cols_lftovr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 288'(out_valid), 288'd0);
        check("rst_in_ready", 288'(in_ready), 288'd0);
        check("rst_done", 288'(done), 288'd0);
        check("rst_data", out_data, 288'd0);
        check("rst_strb", 288'(out_strb), 288'd0);
        check("rst_stored", 288'(stored_cnt), 288'd0);
        check("rst_stall", 288'(stall_cnt), 288'd0);
        @(negedge clk);
        rst = 0;
        // Single full tile, sink always ready.
        run_job(1, 1, 0, 0, FULL, 100, -1, -1, 12);
        // 2 blocks x 3 tiles, last block 4 rows, last tile 5 elements = 10 bytes.
        run_job(2, 3, 4, 5, 36'h0_0000_03FF, 100, -1, -1, 48);
        // Back-pressure: 2x2 tiles, 3-row last block, 7-element last tile = 14 bytes.
        run_job(2, 2, 3, 7, 36'h0_0000_3FFF, 30, -1, -1, 30);
        // Empty job.
        run_job(0, 1, 0, 0, FULL, 100, -1, -1, 0);
        // Clear after the 7th beat is held, then a clean job.
        run_job(1, 1, 0, 0, FULL, 100, -1, 7, 12);
        run_job(1, 1, 0, 0, FULL, 100, -1, -1, 12);
        // Start pulse during RUN is ignored.
        run_job(1, 1, 0, 0, FULL, 100, 5, -1, 12);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
